control_conditioner: RTL and testbench

CONTROL_CONDITIONER -- requirements
Module: control_conditioner

---
 rtl/control_conditioner.sv | 157 +++++++++++++++
 tb/tb_control_conditioner.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_conditioner.sv
// Synchronises, debounces and maps the board keys and switches onto the two player control words.
// Optional macro FIRE_AUTOREPEAT_EN adds a periodic repeat of the fire pulse while a fire key is held.
module control_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_raw,
    input  logic [9:0] sw_raw,
    output logic [7:0] player1_controls,
    output logic [7:0] player2_controls,
    output logic       game_rst,
    output logic [3:0] key_pressed
);

    localparam int N_IN = 14;
    localparam int CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    // Keys idle high (released), switches idle low.
    localparam logic [N_IN-1:0] RST_VAL = {10'b00_0000_0000, 4'b1111};

    logic [N_IN-1:0] raw_s;
    logic [N_IN-1:0] sync1_r;
    logic [N_IN-1:0] sync2_r;
    logic [N_IN-1:0] stable_r;
    logic [N_IN-1:0] stable_nxt_s;
    logic [CW-1:0]   cnt_r     [N_IN];
    logic [CW-1:0]   cnt_nxt_s [N_IN];
    logic [1:0]      stable_d_r;
    logic [3:0]      pressed_s;
    logic [1:0]      rise_s;
    logic [1:0]      fire_s;
    logic            sw8_unused_s;
    logic [7:0]      p1_r;
    logic [7:0]      p2_r;
    logic            game_rst_r;
    logic [3:0]      key_pressed_r;

    assign raw_s = {sw_raw, key_raw};

    // Two-flop synchroniser for every raw input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= RST_VAL;
            sync2_r <= RST_VAL;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-input debounce decision: accept only after a full run of disagreeing cycles.
    always_comb begin
        stable_nxt_s = stable_r;
        for (int i = 0; i < N_IN; i++) begin
            cnt_nxt_s[i] = '0;
            if (sync2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] == CNT_MAX) begin
                stable_nxt_s[i] = sync2_r[i];
                cnt_nxt_s[i]    = '0;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CW'(1);
            end
        end
    end

    // Debounce state registers, plus the previous fire-key levels for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r   <= RST_VAL;
            stable_d_r <= 2'b11;
            for (int i = 0; i < N_IN; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            stable_r   <= stable_nxt_s;
            stable_d_r <= {stable_r[2], stable_r[0]};
            for (int i = 0; i < N_IN; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign pressed_s    = ~stable_r[3:0];
    assign rise_s       = {pressed_s[2] & stable_d_r[1], pressed_s[0] & stable_d_r[0]};
    assign sw8_unused_s = stable_r[12];

`ifdef FIRE_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt_r [2];
    logic [RW-1:0] rep_nxt_s [2];
    logic [1:0]    rep_pulse_s;
    logic [1:0]    held_s;

    assign held_s = {pressed_s[2], pressed_s[0]};

    // Repeat timer restarts on the initial pulse and fires every REPEAT_CYCLES while held.
    always_comb begin
        rep_pulse_s = 2'b00;
        for (int p = 0; p < 2; p++) begin
            rep_nxt_s[p] = '0;
            if (!held_s[p]) begin
                rep_nxt_s[p] = '0;
            end else if (rise_s[p]) begin
                rep_nxt_s[p] = '0;
            end else if (rep_cnt_r[p] == REP_MAX) begin
                rep_nxt_s[p]   = '0;
                rep_pulse_s[p] = 1'b1;
            end else begin
                rep_nxt_s[p] = rep_cnt_r[p] + RW'(1);
            end
        end
    end

    // Per-player repeat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_r[0] <= '0;
            rep_cnt_r[1] <= '0;
        end else begin
            rep_cnt_r[0] <= rep_nxt_s[0];
            rep_cnt_r[1] <= rep_nxt_s[1];
        end
    end

    assign fire_s = rise_s | rep_pulse_s;
`else
    localparam int repeat_cycles_unused = REPEAT_CYCLES;

    assign fire_s = rise_s;
`endif

    // Registered output mapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_r          <= 8'h00;
            p2_r          <= 8'h00;
            game_rst_r    <= 1'b0;
            key_pressed_r <= 4'h0;
        end else begin
            p1_r          <= {fire_s[0], pressed_s[1], 2'b00, stable_r[7:4]};
            p2_r          <= {fire_s[1], pressed_s[3], 2'b00, stable_r[11:8]};
            game_rst_r    <= stable_r[13];
            key_pressed_r <= pressed_s;
        end
    end

    assign player1_controls = p1_r;
    assign player2_controls = p2_r;
    assign game_rst         = game_rst_r;
    assign key_pressed      = key_pressed_r;

endmodule

// File: tb/tb_control_conditioner.sv
// Scoreboard bench: stimulus queues every expected output change; a monitor compares each observed change.
module tb_control_conditioner;

    localparam int DB = 4;
    localparam int RP = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_raw;
    logic [9:0] sw_raw;
    logic [7:0] player1_controls;
    logic [7:0] player2_controls;
    logic       game_rst;
    logic [3:0] key_pressed;

    control_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .key_raw          (key_raw),
        .sw_raw           (sw_raw),
        .player1_controls (player1_controls),
        .player2_controls (player2_controls),
        .game_rst         (game_rst),
        .key_pressed      (key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cycle;
        logic [20:0] snap;
    } ev_t;

    ev_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    logic [7:0] e_p1  = 8'h00;
    logic [7:0] e_p2  = 8'h00;
    logic       e_grst = 1'b0;
    logic [3:0] e_kp  = 4'h0;

    task automatic push(input int c);
        ev_t e;
        e.cycle = c;
        e.snap  = {e_p1, e_p2, e_grst, e_kp};
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected fire pulses for a key pressed at t0 and held for hold cycles.
    task automatic expect_fire(input int t0, input int hold, input bit p2);
        int last;
        last = 7;
`ifdef FIRE_AUTOREPEAT_EN
        last = hold + 6;
`endif
        for (int off = 7; off <= last; off += RP) begin
            if (p2) e_p2[7] = 1'b1; else e_p1[7] = 1'b1;
            push(t0 + off);
            if (p2) e_p2[7] = 1'b0; else e_p1[7] = 1'b0;
            push(t0 + off + 1);
        end
    endtask

    logic [20:0] prev_snap = 21'h0;

    always @(negedge clk) begin
        logic [20:0] snap;
        ev_t e;
        snap = {player1_controls, player2_controls, game_rst, key_pressed};
        if (snap !== prev_snap) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%h", cyc, snap);
            end else begin
                e = exp_q.pop_front();
                if (e.cycle != cyc || snap !== e.snap) begin
                    failures++;
                    $display("FAIL output_event cyc=%0d exp_cyc=%0d got=%h exp=%h",
                             cyc, e.cycle, snap, e.snap);
                end
            end
            prev_snap = snap;
        end
    end

    initial begin
        int t;
        rst_n   = 1'b1;
        key_raw = 4'hF;
        sw_raw  = 10'h000;
        #1 rst_n = 1'b0;
        step(3);
        checks++;
        if ({player1_controls, player2_controls, game_rst, key_pressed} !== 21'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0",
                     {player1_controls, player2_controls, game_rst, key_pressed});
        end
        rst_n = 1'b1;
        step(5);

        // Clean press and release of KEY[0].
        t = cyc;
        key_raw[0] = 1'b0;
        e_kp[0] = 1'b1;
        expect_fire(t, 10, 1'b0);
        step(10);
        t = cyc;
        key_raw[0] = 1'b1;
        e_kp[0] = 1'b0;
        push(t + 7);
        step(15);

        // Short glitches on KEY[2] must never be accepted.
        repeat (5) begin
            key_raw[2] = 1'b0;
            step(3);
            key_raw[2] = 1'b1;
            step(3);
        end
        step(10);
        checks++;
        if (key_pressed[2] !== 1'b0) begin
            failures++;
            $display("FAIL glitch_pressed got=%b exp=0", key_pressed[2]);
        end
        checks++;
        if (player2_controls[7] !== 1'b0) begin
            failures++;
            $display("FAIL glitch_fire got=%b exp=0", player2_controls[7]);
        end

        // Switch mapping, unused SW[8], then game reset.
        t = cyc;
        sw_raw = 10'h0A5;
        e_p1 = 8'h05;
        e_p2 = 8'h0A;
        push(t + 7);
        step(10);
        sw_raw[8] = 1'b1;
        step(10);
        t = cyc;
        sw_raw[9] = 1'b1;
        e_grst = 1'b1;
        push(t + 7);
        step(10);

        // Simultaneous thrust on both players.
        t = cyc;
        key_raw[1] = 1'b0;
        key_raw[3] = 1'b0;
        e_p1 = 8'h45;
        e_p2 = 8'h4A;
        e_kp = 4'b1010;
        push(t + 7);
        step(10);
        t = cyc;
        key_raw[1] = 1'b1;
        key_raw[3] = 1'b1;
        e_p1 = 8'h05;
        e_p2 = 8'h0A;
        e_kp = 4'b0000;
        push(t + 7);
        step(10);

        // KEY[0] held for 30 cycles.
        t = cyc;
        key_raw[0] = 1'b0;
        e_kp[0] = 1'b1;
        expect_fire(t, 30, 1'b0);
        step(30);
        t = cyc;
        key_raw[0] = 1'b1;
        e_kp[0] = 1'b0;
        push(t + 7);
        step(15);

        // Return switches to zero before the reset test.
        t = cyc;
        sw_raw = 10'h000;
        e_p1 = 8'h00;
        e_p2 = 8'h00;
        e_grst = 1'b0;
        push(t + 7);
        step(12);

        // Reset in the middle of a KEY[0] debounce, key still held afterwards.
        key_raw[0] = 1'b0;
        step(3);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        t = cyc;
        e_kp[0] = 1'b1;
        expect_fire(t, 12, 1'b0);
        step(12);
        t = cyc;
        key_raw[0] = 1'b1;
        e_kp[0] = 1'b0;
        push(t + 7);
        step(20);

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event exp_cyc=%0d exp=%h", e.cycle, e.snap);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
